// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder sequencer.
package adder_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } seq_state_t;

endpackage

// File: rtl/nibble_cin_merge.sv
// Folds an incoming carry into a 4-bit adder result that lacks a carry-in.
module nibble_cin_merge
  import adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] sum,
  input  logic                cout,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] nib,
  output logic                carry_next
);

  assign nib = sum + NIBBLE_W'(cin);
  // sum==F with cin set cannot coincide with cout, so OR-ing never double-counts
  assign carry_next = cout | (cin & (sum == '1));

endmodule

// File: rtl/nibble_serial_add_seq.sv
// Nibble-serial sequencer: feeds an external 4-bit adder LSB nibble first and
// assembles the full-width sum, merging the inter-nibble carry locally.
module nibble_serial_add_seq
  import adder_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]   s_a,
  input  logic [NIBBLE_W*NIBBLES-1:0]   s_b,
  output logic [NIBBLE_W-1:0]           add_a,
  output logic [NIBBLE_W-1:0]           add_b,
  input  logic [NIBBLE_W-1:0]           add_sum,
  input  logic                          add_cout,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]   m_sum,
  output logic                          m_cout
);

  localparam int unsigned WIDTH = NIBBLE_W * NIBBLES;
  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  seq_state_t       state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, res, res_next;
  logic [IDX_W-1:0] idx;
  logic             carry, carry_next;
  logic [NIBBLE_W-1:0] nib;
  logic             last;

  assign last = (idx == IDX_W'(NIBBLES - 1));

  nibble_cin_merge u_merge (
    .sum        (add_sum),
    .cout       (add_cout),
    .cin        (carry),
    .nib        (nib),
    .carry_next (carry_next)
  );

  // New nibble enters at the MSB end so the first nibble lands at the bottom
  if (NIBBLES == 1) begin : g_res_one
    assign res_next = nib;
  end else begin : g_res_many
    assign res_next = {nib, res[WIDTH-1:NIBBLE_W]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    unique case (state)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) state_next = RUN;
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        m_valid = 1'b1;
        if (m_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      carry <= 1'b0;
      idx   <= '0;
    end else if (state == IDLE && s_valid) begin
      a_sh  <= s_a;
      b_sh  <= s_b;
      res   <= '0;
      carry <= 1'b0;
      idx   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> NIBBLE_W;
      b_sh  <= b_sh >> NIBBLE_W;
      res   <= res_next;
      carry <= carry_next;
      idx   <= idx + IDX_W'(1);
    end
  end

  assign add_a  = (state == RUN) ? a_sh[NIBBLE_W-1:0] : '0;
  assign add_b  = (state == RUN) ? b_sh[NIBBLE_W-1:0] : '0;
  assign m_sum  = m_valid ? res : '0;
  assign m_cout = m_valid & carry;

endmodule

// File: tb/tb_nibble_serial_add_seq.sv
// Randomized and directed bench for nibble_serial_add_seq against an A+B reference.
module tb_nibble_serial_add_seq;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned WIDTH   = 4 * NIBBLES;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [WIDTH-1:0] s_a = '0;
  logic [WIDTH-1:0] s_b = '0;
  logic [3:0]       add_a, add_b, add_sum;
  logic             add_cout;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [WIDTH-1:0] m_sum;
  logic             m_cout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Stand-in for the Kogge-Stone stage that sits beside the DUT in the project
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

  nibble_serial_add_seq #(.NIBBLES(NIBBLES)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_a      (s_a),
    .s_b      (s_b),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_sum    (m_sum),
    .m_cout   (m_cout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered and left 1ns after a rising edge.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input int gap, input int hold);
    logic [WIDTH:0] expv;
    int k;
    expv = {1'b0, a} + {1'b0, b};
    repeat (gap) tick();
    s_valid = 1'b1;
    s_a = a;
    s_b = b;
    k = 0;
    while (!s_ready && k < 20) begin
      tick();
      k++;
    end
    check("accept_wait", 32'(k < 20), 32'd1);
    tick();
    s_valid = 1'b0;
    s_a = WIDTH'($urandom);
    s_b = WIDTH'($urandom);
    check("run_sready", 32'(s_ready), 32'd0);
    k = 0;
    while (!m_valid && k < 20) begin
      tick();
      k++;
    end
    check("latency", 32'(k), 32'(NIBBLES));
    check("sum", 32'(m_sum), 32'(expv[WIDTH-1:0]));
    check("cout", 32'(m_cout), 32'(expv[WIDTH]));
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", 32'(m_valid), 32'd1);
      check("hold_sum", 32'(m_sum), 32'(expv[WIDTH-1:0]));
      check("hold_cout", 32'(m_cout), 32'(expv[WIDTH]));
      check("hold_sready", 32'(s_ready), 32'd0);
    end
    m_ready = 1'b1;
    #1;
    check("done_sready", 32'(s_ready), 32'd0);
    tick();
    m_ready = 1'b0;
    check("idle_valid", 32'(m_valid), 32'd0);
    check("idle_sready", 32'(s_ready), 32'd1);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1;
    check("rst_sready", 32'(s_ready), 32'd1);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_sum", 32'(m_sum), 32'd0);
    check("rst_cout", 32'(m_cout), 32'd0);
    check("rst_adda", 32'(add_a), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    do_op(16'h1234, 16'h4321, 0, 0);
    do_op(16'h00FF, 16'h0001, 1, 0);
    do_op(16'hFFFF, 16'h0001, 0, 0);
    do_op(16'h8000, 16'h8000, 0, 0);
    // Backpressure, then an immediate back-to-back accept
    do_op(16'hABCD, 16'h6789, 0, 3);
    do_op(16'h0F0F, 16'h0001, 0, 0);

    // Reset during RUN at idx=2
    s_valid = 1'b1;
    s_a = 16'h1111;
    s_b = 16'h2222;
    tick();
    s_valid = 1'b0;
    tick();
    tick();
    check("mid_adda", 32'(add_a), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(m_valid), 32'd0);
    check("mid_rst_sready", 32'(s_ready), 32'd1);
    check("mid_rst_sum", 32'(m_sum), 32'd0);
    check("mid_rst_cout", 32'(m_cout), 32'd0);
    check("mid_rst_adda", 32'(add_a), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_rst_nopulse", 32'(m_valid), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_valid", 32'(m_valid), 32'd0);
    do_op(16'h0F0F, 16'hF0F1, 0, 0);

    for (int n = 0; n < 1000; n++) begin
      do_op(WIDTH'($urandom), WIDTH'($urandom), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
